sevenseg_reader: RTL and testbench
==================================

# sevenseg_reader

Receive-side counterpart of the team's seven-segment digit encoder. The block observes a multiplexed, active-high seven-segment display bus, consisting of segment lines plus one-hot digit enables. It waits for each segment pattern to be stable, decodes it back to a 4-bit BCD value and assembles a complete multi-digit frame, which it hands downstream over a valid/ready handshake. It sits between a display-scan source (or a display-bus tap) and any logic that needs the displayed number back in binary, such as self-check, loopback test or a readback register.

## Interface
- `NDIGITS`, default 4: number of multiplexed digits (1..8).
- `STABLE_CYCLES`, default 3: consecutive identical samples required before a capture (minimum 2).

- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `seg_in`, input, 7: segment lines `{a,b,c,d,e,f,g}`, MSB = a, active-high.
- `dig_en`, input, NDIGITS: digit enables, active-high, expected one-hot.
- `frame_data`, output, 4*NDIGITS: decoded frame; digit i is `[4i+3:4i]`.
- `frame_valid`, output, 1: `frame_data` is valid; held until accepted.
- `frame_ready`, input, 1: downstream accepts the frame when high together with `frame_valid`.
- `seg_err`, output, 1: one-cycle pulse when a stable pattern is not a legal code.
- `err_digit`, output, 3: index of the digit that raised the last `seg_err`; held between errors.

## Operation
- **Legal codes** (`seg_in` → value):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1110011→9
  - Every other pattern is illegal.
- **Sample register and counter:**
  - Sample register `s = {dig_en, seg_in}` and counter `cnt`, width `$clog2(STABLE_CYCLES+1)`.
  - Each edge, if the input equals `s`, `cnt` increments and saturates at `STABLE_CYCLES`.
  - Otherwise `s` is loaded with the input and `cnt` is set to 1.
- **Capture:**
  - Capture occurs at the edge where the input matches `s` and `cnt == STABLE_CYCLES-1`.
  - This gives exactly one capture per dwell; the saturated count blocks any repeat.
  - Capture is suppressed if `dig_en` in `s` is not one-hot (all zero or multiple bits set). No error is raised in that case.
- **Legal capture at digit i:**
  - The decoded value is written to the internal digit register i.
  - Mask bit i is set.
- **Illegal capture at digit i:**
  - The digit register is unchanged and mask bit i is cleared.
  - `seg_err` pulses for one cycle and `err_digit` is set to i.
- **Frame assembly:**
  - When the mask is all ones and no frame is pending (`frame_valid == 0`), the digit registers are copied to `frame_data` and `frame_valid` is set, both at the next edge.
  - The mask is cleared at that same edge.
- **Pending frame:**
  - While `frame_valid == 1`, `frame_data` is frozen and accumulation into the digit registers and mask continues.
- **Handshake:** `frame_valid` clears at the edge where `frame_valid && frame_ready`.
  - Back-to-back: if the mask is full at that edge, the new frame is latched instead. `frame_valid` stays 1 and `frame_data` updates.
- **Reset:**
  - The partial frame, the pending frame and the stability state are all discarded.
  - Reset values: `frame_data` = 0, `frame_valid` = 0, `seg_err` = 0, `err_digit` = 0; internal `s`, `cnt`, mask and digit registers = 0.

## Timing
- If the input is presented before edge E0 and held, `s` loads at E0 (`cnt` = 1).
- Capture then occurs at edge E(STABLE_CYCLES-1), i.e. E2 for the default.
- `frame_valid` rises at the edge following the capture that completes the mask; minimum latency is 1 cycle after the last capture.
- `seg_err` is high for exactly the cycle after the illegal capture edge.
- A glitch shorter than `STABLE_CYCLES-1` cycles produces no capture and no error.
- `frame_ready` may be held high permanently. `frame_valid` must not depend combinationally on `frame_ready`.
- Throughput: with `frame_ready` held high, one frame per NDIGITS completed dwells.

## Configuration
- `SEVENSEG_READER_BLANK_EN`:
  - **Defined:** pattern 0000000 is legal, decodes to 4'hF (blank) and sets the mask bit.
  - **Undefined:** 0000000 is illegal and raises `seg_err`.

## Test plan
- **Basic frame:** NDIGITS=4, STABLE=3; scan digits 0..3 with codes 3, 1, 4, 1, each held for 4 cycles, `frame_ready` = 1 → `frame_data` = 16'h1413 with `frame_valid` high for one cycle; no `seg_err`.
- **Glitch rejection:** hold digit 0 at "5", insert a 1-cycle pattern 1111111, then return to "5" for 3 cycles → one capture of 5, no capture of 8, no `seg_err`.
- **Illegal pattern:** digit 2 stable at 0001000 for 3 cycles → `seg_err` one-cycle pulse, `err_digit` = 2, no frame until digit 2 is recaptured legally.
- **Backpressure:** `frame_ready` = 0; complete frame A = 16'h2222, then frame B = 16'h9876 → `frame_data` stays 16'h2222. Raise `frame_ready` for one cycle → `frame_valid` stays high and `frame_data` = 16'h9876 on the next cycle.
- **Reset mid-frame:** after 2 of 4 digits are captured, assert `reset` for 1 cycle → all outputs 0. Two further digits alone produce no frame; a full 4-digit scan is required.
- **Blank code:** pattern 0000000 with the macro defined → digit value 4'hF, frame produced. Without the macro → `seg_err` pulse and no frame.

Source files
------------

// File: rtl/sevenseg_reader.sv
// Seven-segment bus reader: debounces each multiplexed digit, decodes it to BCD and
// hands out complete frames over valid/ready. Define SEVENSEG_READER_BLANK_EN to accept 0000000 as blank (4'hF).
module sevenseg_reader #(
   parameter int NDIGITS       = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [6:0]             seg_in,
   input  logic [NDIGITS-1:0]     dig_en,
   output logic [4*NDIGITS-1:0]   frame_data,
   output logic                   frame_valid,
   input  logic                   frame_ready,
   output logic                   seg_err,
   output logic [2:0]             err_digit
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int SW = NDIGITS + 7;

   typedef logic [CW-1:0]      cnt_t;
   typedef logic [NDIGITS-1:0] en_t;

   localparam cnt_t CNT_MAX = cnt_t'(STABLE_CYCLES);
   localparam cnt_t CNT_CAP = cnt_t'(STABLE_CYCLES - 1);

   logic [SW-1:0]             s_q, s_d;
   cnt_t                      cnt_q, cnt_d;
   en_t                       mask_q, mask_d;
   logic [NDIGITS-1:0][3:0]   digits_q, digits_d;
   logic [4*NDIGITS-1:0]      frame_data_q, frame_data_d;
   logic                      frame_valid_q, frame_valid_d;
   logic                      seg_err_q, seg_err_d;
   logic [2:0]                err_digit_q, err_digit_d;

   logic [SW-1:0] samp_in;
   logic          match;
   logic          onehot;
   logic          capture;
   logic          load;
   en_t           en_s;
   logic [4:0]    dec;

   // Returns {legal, value}.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      case (seg)
         7'b1111110: decode = {1'b1, 4'd0};
         7'b0110000: decode = {1'b1, 4'd1};
         7'b1101101: decode = {1'b1, 4'd2};
         7'b1111001: decode = {1'b1, 4'd3};
         7'b0110011: decode = {1'b1, 4'd4};
         7'b1011011: decode = {1'b1, 4'd5};
         7'b1011111: decode = {1'b1, 4'd6};
         7'b1110000: decode = {1'b1, 4'd7};
         7'b1111111: decode = {1'b1, 4'd8};
         7'b1110011: decode = {1'b1, 4'd9};
`ifdef SEVENSEG_READER_BLANK_EN
         7'b0000000: decode = {1'b1, 4'hF};
`endif
         default:    decode = {1'b0, 4'h0};
      endcase
   endfunction

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      samp_in       = {dig_en, seg_in};
      match         = (samp_in == s_q);
      s_d           = s_q;
      cnt_d         = cnt_q;
      mask_d        = mask_q;
      digits_d      = digits_q;
      frame_data_d  = frame_data_q;
      frame_valid_d = frame_valid_q;
      seg_err_d     = 1'b0;
      err_digit_d   = err_digit_q;

      if (match) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + cnt_t'(1);
      end else begin
         s_d   = samp_in;
         cnt_d = cnt_t'(1);
      end

      en_s    = s_q[SW-1:7];
      onehot  = (en_s != '0) && ((en_s & (en_s - en_t'(1))) == '0);
      capture = match && (cnt_q == CNT_CAP) && onehot;
      dec     = decode(s_q[6:0]);

      // A full mask can be handed out when nothing is pending or the pending frame leaves this edge.
      load = (&mask_q) && (!frame_valid_q || frame_ready);
      if (load) begin
         mask_d        = '0;
         frame_data_d  = digits_q;
         frame_valid_d = 1'b1;
      end else if (frame_valid_q && frame_ready) begin
         frame_valid_d = 1'b0;
      end

      if (capture) begin
         for (int i = 0; i < NDIGITS; i++) begin
            if (en_s[i]) begin
               if (dec[4]) begin
                  digits_d[i] = dec[3:0];
                  mask_d[i]   = 1'b1;
               end else begin
                  mask_d[i]   = 1'b0;
                  seg_err_d   = 1'b1;
                  err_digit_d = 3'(i);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers update with non-blocking assignments so all see pre-edge values.
      if (reset) begin
         s_q           <= '0;
         cnt_q         <= '0;
         mask_q        <= '0;
         digits_q      <= '0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         seg_err_q     <= 1'b0;
         err_digit_q   <= '0;
      end else begin
         s_q           <= s_d;
         cnt_q         <= cnt_d;
         mask_q        <= mask_d;
         digits_q      <= digits_d;
         frame_data_q  <= frame_data_d;
         frame_valid_q <= frame_valid_d;
         seg_err_q     <= seg_err_d;
         err_digit_q   <= err_digit_d;
      end
   end

   assign frame_data  = frame_data_q;
   assign frame_valid = frame_valid_q;
   assign seg_err     = seg_err_q;
   assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Bench for sevenseg_reader: table of decode vectors plus hand-written corner sequences,
// with expected frames and errors queued at stimulus time and popped when the DUT produces them.
module tb_sevenseg_reader;

   localparam int ND = 4;

   localparam logic [6:0] C0  = 7'b1111110;
   localparam logic [6:0] C1  = 7'b0110000;
   localparam logic [6:0] C2  = 7'b1101101;
   localparam logic [6:0] C3  = 7'b1111001;
   localparam logic [6:0] C4  = 7'b0110011;
   localparam logic [6:0] C5  = 7'b1011011;
   localparam logic [6:0] C6  = 7'b1011111;
   localparam logic [6:0] C7  = 7'b1110000;
   localparam logic [6:0] C8  = 7'b1111111;
   localparam logic [6:0] C9  = 7'b1110011;
   localparam logic [6:0] ILL = 7'b0001000;

   logic                clk = 1'b0;
   logic                reset;
   logic [6:0]          seg_in;
   logic [ND-1:0]       dig_en;
   logic [4*ND-1:0]     frame_data;
   logic                frame_valid;
   logic                frame_ready;
   logic                seg_err;
   logic [2:0]          err_digit;

   int checks   = 0;
   int failures = 0;

   logic [15:0]   exp_frames[$];
   logic [2:0]    exp_errs[$];
   logic [3:0]    m_dig[ND];
   logic [ND-1:0] m_mask;

   typedef struct {
      logic [6:0] seg;
      int         dig;
      logic       legal;
      logic [3:0] val;
   } vec_t;

   vec_t vecs[18];

   always #5 clk = ~clk;

   sevenseg_reader #(.NDIGITS(ND), .STABLE_CYCLES(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .seg_in      (seg_in),
      .dig_en      (dig_en),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .seg_err     (seg_err),
      .err_digit   (err_digit)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] ref_dec(input logic [6:0] seg);
      case (seg)
         C0: ref_dec = 5'h10;
         C1: ref_dec = 5'h11;
         C2: ref_dec = 5'h12;
         C3: ref_dec = 5'h13;
         C4: ref_dec = 5'h14;
         C5: ref_dec = 5'h15;
         C6: ref_dec = 5'h16;
         C7: ref_dec = 5'h17;
         C8: ref_dec = 5'h18;
         C9: ref_dec = 5'h19;
`ifdef SEVENSEG_READER_BLANK_EN
         7'b0000000: ref_dec = 5'h1F;
`endif
         default: ref_dec = 5'h00;
      endcase
   endfunction

   // Monitor: sample away from the rising edge and pop the scoreboards.
   always @(negedge clk) begin
      if (!reset) begin
         if (frame_valid && frame_ready) begin
            if (exp_frames.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_frame: got %0h expected none", frame_data);
            end else begin
               check("frame_data", 32'(frame_data), 32'(exp_frames.pop_front()));
            end
         end
         if (seg_err) begin
            if (exp_errs.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_seg_err: got digit %0d expected none", err_digit);
            end else begin
               check("err_digit", 32'(err_digit), 32'(exp_errs.pop_front()));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [ND-1:0] en, input logic [6:0] seg, input int n);
      dig_en = en;
      seg_in = seg;
      repeat (n) step();
   endtask

   task automatic idle(input int n);
      drive('0, 7'b0, n);
   endtask

   task automatic model_capture(input int d, input logic [4:0] e);
      if (e[4]) begin
         m_dig[d]  = e[3:0];
         m_mask[d] = 1'b1;
         if (&m_mask) begin
            exp_frames.push_back({m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
            m_mask = '0;
         end
      end else begin
         m_mask[d] = 1'b0;
         exp_errs.push_back(3'(d));
      end
   endtask

   task automatic scan_exp(input int d, input logic [6:0] seg, input logic [4:0] e, input int n);
      logic [ND-1:0] en;
      en    = '0;
      en[d] = 1'b1;
      if (n >= 3) model_capture(d, e);
      drive(en, seg, n);
   endtask

   task automatic scan(input int d, input logic [6:0] seg);
      scan_exp(d, seg, ref_dec(seg), 4);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(1);
      reset  = 1'b0;
      m_mask = '0;
   endtask

   initial begin
      vecs[0]  = '{C0, 0, 1'b1, 4'd0};
      vecs[1]  = '{C1, 1, 1'b1, 4'd1};
      vecs[2]  = '{C2, 2, 1'b1, 4'd2};
      vecs[3]  = '{C3, 3, 1'b1, 4'd3};
      vecs[4]  = '{C4, 0, 1'b1, 4'd4};
      vecs[5]  = '{C5, 1, 1'b1, 4'd5};
      vecs[6]  = '{C6, 2, 1'b1, 4'd6};
      vecs[7]  = '{C7, 3, 1'b1, 4'd7};
      vecs[8]  = '{C8, 0, 1'b1, 4'd8};
      vecs[9]  = '{C9, 1, 1'b1, 4'd9};
      vecs[10] = '{ILL,        2, 1'b0, 4'd0};
      vecs[11] = '{7'b1000000, 3, 1'b0, 4'd0};
      vecs[12] = '{7'b0000001, 0, 1'b0, 4'd0};
      vecs[13] = '{7'b1111100, 1, 1'b0, 4'd0};
      vecs[14] = '{C1, 2, 1'b1, 4'd1};
      vecs[15] = '{C9, 3, 1'b1, 4'd9};
      vecs[16] = '{C5, 0, 1'b1, 4'd5};
      vecs[17] = '{C2, 1, 1'b1, 4'd2};

      reset       = 1'b1;
      frame_ready = 1'b0;
      dig_en      = '0;
      seg_in      = '0;
      m_mask      = '0;
      for (int i = 0; i < ND; i++) m_dig[i] = '0;
      repeat (2) step();
      check("reset_frame_data", 32'(frame_data), 32'h0);
      check("reset_frame_valid", 32'(frame_valid), 32'h0);
      check("reset_seg_err", 32'(seg_err), 32'h0);
      check("reset_err_digit", 32'(err_digit), 32'h0);
      reset = 1'b0;

      // Basic frame 3,1,4,1 -> 16'h1413
      frame_ready = 1'b1;
      scan(0, C3);
      scan(1, C1);
      scan(2, C4);
      scan(3, C1);
      idle(3);

      // Glitch rejection, plus the 2-cycle hold boundary that must not capture
      scan(0, C5);
      drive(4'b0001, C8, 1);
      scan_exp(0, C5, ref_dec(C5), 3);
      drive(4'b0010, ILL, 1);
      idle(1);
      drive(4'b0010, ILL, 2);
      idle(1);
      scan(1, C7);
      scan(2, C2);
      scan(3, C0);
      idle(3);

      // Illegal pattern at digit 2 blocks the frame until recaptured
      scan(0, C1);
      scan(1, C2);
      scan_exp(2, ILL, ref_dec(ILL), 3);
      scan(3, C3);
      idle(4);
      check("illegal_no_frame", 32'(frame_valid), 32'h0);
      check("err_digit_held", 32'(err_digit), 32'h2);
      check("seg_err_one_cycle", 32'(seg_err), 32'h0);
      scan(2, C4);
      idle(3);

      // Non-one-hot enables never capture or raise errors
      drive(4'b0000, ILL, 4);
      drive(4'b0011, ILL, 4);
      drive(4'b1100, C8, 4);
      idle(2);

      // Blank code: legal with the macro, error otherwise
      scan(0, C9);
      scan(1, 7'b0000000);
      scan(2, C0);
      scan(3, C1);
      idle(3);
      do_reset();

      // Decode table
      for (int i = 0; i < 18; i++) begin
         scan_exp(vecs[i].dig, vecs[i].seg, {vecs[i].legal, vecs[i].val}, 4);
      end
      idle(3);
      do_reset();

      // Backpressure and back-to-back handoff
      frame_ready = 1'b0;
      scan(0, C2);
      scan(1, C2);
      scan(2, C2);
      scan(3, C2);
      idle(2);
      check("bp_valid_a", 32'(frame_valid), 32'h1);
      check("bp_data_a", 32'(frame_data), 32'h2222);
      scan(0, C6);
      scan(1, C7);
      scan(2, C8);
      scan(3, C9);
      idle(2);
      check("bp_valid_held", 32'(frame_valid), 32'h1);
      check("bp_data_frozen", 32'(frame_data), 32'h2222);
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      check("b2b_valid", 32'(frame_valid), 32'h1);
      check("b2b_data", 32'(frame_data), 32'h9876);
      idle(2);
      frame_ready = 1'b1;
      idle(3);

      // Reset mid-frame discards the partial frame
      scan(0, C1);
      scan(1, C2);
      do_reset();
      check("rst_frame_data", 32'(frame_data), 32'h0);
      check("rst_frame_valid", 32'(frame_valid), 32'h0);
      check("rst_seg_err", 32'(seg_err), 32'h0);
      check("rst_err_digit", 32'(err_digit), 32'h0);
      scan(2, C3);
      scan(3, C4);
      idle(4);
      check("rst_partial_no_frame", 32'(frame_valid), 32'h0);
      scan(0, C5);
      scan(1, C6);
      scan(2, C7);
      scan(3, C8);
      idle(3);

      for (int i = 0; i < 50; i++) begin
         if (exp_frames.size() == 0 && exp_errs.size() == 0) break;
         step();
      end
      check("pending_frames", 32'(exp_frames.size()), 32'h0);
      check("pending_errors", 32'(exp_errs.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
